// File: rtl/led_ram_arbiter.sv
// Arbitrates one LED frame RAM between scan reads, light-pen writes and full-frame clear sweeps.
// Latency: grant to RAM address is 1 cycle; scan grant to scan_valid/scan_data is 2 cycles.
// Backpressure: pen_req is held until pen_ack; a starved pen preempts scan; a clear stalls both.
module led_ram_arbiter #(
    parameter int         PEN_MAX_WAIT = 4,
    parameter logic [3:0] CLR_DATA     = 4'b0000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scan_req,
    input  logic [7:0] scan_row,
    input  logic [7:0] scan_col,
    output logic       scan_valid,
    output logic [3:0] scan_data,
    input  logic       pen_req,
    input  logic [7:0] pen_row,
    input  logic [7:0] pen_col,
    input  logic [3:0] pen_data,
    output logic       pen_ack,
    output logic       pen_err,
    input  logic       clr_start,
    output logic       clr_busy,
    output logic       clr_done,
    output logic       ram_we,
    output logic [7:0] ram_row,
    output logic [7:0] ram_col,
    output logic [3:0] ram_wdata,
    input  logic [3:0] ram_rdata
);

    localparam int            WW       = (PEN_MAX_WAIT < 1) ? 1 : $clog2(PEN_MAX_WAIT + 1);
    localparam logic [WW-1:0] WAIT_MAX = WW'(PEN_MAX_WAIT);

    typedef enum logic {RUN, CLEAR} state_t;

    state_t        state_q, state_d;
    logic [5:0]    idx_q, idx_d;
    logic [WW-1:0] wait_q, wait_d;
    logic          scan_rd_q;
    logic          pen_grant, scan_grant, clr_wr, clr_last, pen_ok;

    assign pen_ok = $onehot(pen_row) && $onehot(pen_col);

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        wait_d     = wait_q;
        pen_grant  = 1'b0;
        scan_grant = 1'b0;
        clr_wr     = 1'b0;
        clr_last   = 1'b0;
        case (state_q)
            RUN: begin
                if (clr_start) begin
                    state_d = CLEAR;
                    idx_d   = 6'd0;
                end else if (pen_req && (!scan_req || wait_q == WAIT_MAX)) begin
                    pen_grant = 1'b1;
                end else if (scan_req) begin
                    scan_grant = 1'b1;
                end
                if (!pen_req || pen_grant)
                    wait_d = '0;
                else if (wait_q != WAIT_MAX)
                    wait_d = wait_q + 1'b1;
            end
            CLEAR: begin
                // Index wraps 63 -> 0 on exit, leaving it ready for the next sweep.
                clr_wr = 1'b1;
                idx_d  = idx_q + 6'd1;
                if (idx_q == 6'd63) begin
                    state_d  = RUN;
                    clr_last = 1'b1;
                end
                if (!pen_req)
                    wait_d = '0;
            end
            default: state_d = RUN;
        endcase
    end

    assign pen_ack  = pen_grant;
    assign pen_err  = pen_grant && !pen_ok;
    assign clr_busy = (state_q == CLEAR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            idx_q      <= 6'd0;
            wait_q     <= '0;
            scan_rd_q  <= 1'b0;
            scan_valid <= 1'b0;
            scan_data  <= 4'h0;
            clr_done   <= 1'b0;
            ram_we     <= 1'b0;
            ram_row    <= 8'h00;
            ram_col    <= 8'h00;
            ram_wdata  <= 4'h0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            wait_q     <= wait_d;
            clr_done   <= clr_last;
            ram_we     <= clr_wr || (pen_grant && pen_ok);
            // Address/data registers hold when idle or on a rejected pen request.
            if (clr_wr) begin
                ram_row   <= 8'b1 << idx_q[5:3];
                ram_col   <= 8'b1 << idx_q[2:0];
                ram_wdata <= CLR_DATA;
            end else if (pen_grant && pen_ok) begin
                ram_row   <= pen_row;
                ram_col   <= pen_col;
                ram_wdata <= pen_data;
            end else if (scan_grant) begin
                ram_row   <= scan_row;
                ram_col   <= scan_col;
            end
            scan_rd_q  <= scan_grant;
            scan_valid <= scan_rd_q;
            if (scan_rd_q)
                scan_data <= ram_rdata;
        end
    end

endmodule

// File: tb/tb_led_ram_arbiter.sv
// Directed bench for led_ram_arbiter with a behavioural frame RAM (read data follows the registered address).
module tb_led_ram_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       scan_req;
    logic [7:0] scan_row, scan_col;
    logic       scan_valid;
    logic [3:0] scan_data;
    logic       pen_req;
    logic [7:0] pen_row, pen_col;
    logic [3:0] pen_data;
    logic       pen_ack, pen_err;
    logic       clr_start, clr_busy, clr_done;
    logic       ram_we;
    logic [7:0] ram_row, ram_col;
    logic [3:0] ram_wdata, ram_rdata;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] c;
        logic [3:0] d;
    } wr_t;

    logic [3:0] mem [8][8];
    logic       pl_en;
    logic [2:0] pl_r, pl_c;
    logic [3:0] pl_d;

    wr_t        exp_wr[$];
    logic [3:0] exp_scan[$];
    int         vectors = 0;
    int         miscompares = 0;

    always #5 clk = ~clk;

    led_ram_arbiter #(.PEN_MAX_WAIT(4), .CLR_DATA(4'b0000)) dut (
        .clk(clk), .rst_n(rst_n),
        .scan_req(scan_req), .scan_row(scan_row), .scan_col(scan_col),
        .scan_valid(scan_valid), .scan_data(scan_data),
        .pen_req(pen_req), .pen_row(pen_row), .pen_col(pen_col), .pen_data(pen_data),
        .pen_ack(pen_ack), .pen_err(pen_err),
        .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
        .ram_we(ram_we), .ram_row(ram_row), .ram_col(ram_col),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    function automatic logic [2:0] bit_idx(input logic [7:0] v);
        logic [2:0] r;
        r = 3'd0;
        for (int k = 0; k < 8; k++)
            if (v[k]) r = 3'(k);
        return r;
    endfunction

    assign ram_rdata = ($onehot(ram_row) && $onehot(ram_col)) ?
                       mem[bit_idx(ram_row)][bit_idx(ram_col)] : 4'h0;

    always @(posedge clk) begin
        if (pl_en)
            mem[pl_r][pl_c] <= pl_d;
        else if (rst_n && ram_we && $onehot(ram_row) && $onehot(ram_col))
            mem[bit_idx(ram_row)][bit_idx(ram_col)] <= ram_wdata;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every RAM write and every scan_valid must match the next queued expectation.
    task automatic monitor();
        wr_t o;
        if (!rst_n) return;
        if (ram_we) begin
            o.r = ram_row; o.c = ram_col; o.d = ram_wdata;
            if (exp_wr.size() == 0) check("ram_wr_unexpected", 32'(o), 32'hFFFFFFFF);
            else check("ram_wr", 32'(o), 32'(exp_wr.pop_front()));
        end
        if (scan_valid) begin
            if (exp_scan.size() == 0) check("scan_unexpected", 32'(scan_data), 32'hFFFFFFFF);
            else check("scan_data", 32'(scan_data), 32'(exp_scan.pop_front()));
        end
    endtask

    task automatic smp();
        @(negedge clk);
        monitor();
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic push_wr(input logic [7:0] r, input logic [7:0] c, input logic [3:0] d);
        wr_t w;
        w.r = r; w.c = c; w.d = d;
        exp_wr.push_back(w);
    endtask

    task automatic push_clear(input int n);
        logic [5:0] ix;
        for (int i = 0; i < n; i++) begin
            ix = 6'(i);
            push_wr(8'b1 << ix[5:3], 8'b1 << ix[2:0], 4'h0);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ram_we"},     32'(ram_we),     32'h0);
        check({tag, "_ram_row"},    32'(ram_row),    32'h0);
        check({tag, "_ram_col"},    32'(ram_col),    32'h0);
        check({tag, "_ram_wdata"},  32'(ram_wdata),  32'h0);
        check({tag, "_scan_valid"}, 32'(scan_valid), 32'h0);
        check({tag, "_scan_data"},  32'(scan_data),  32'h0);
        check({tag, "_pen_ack"},    32'(pen_ack),    32'h0);
        check({tag, "_pen_err"},    32'(pen_err),    32'h0);
        check({tag, "_clr_busy"},   32'(clr_busy),   32'h0);
        check({tag, "_clr_done"},   32'(clr_done),   32'h0);
    endtask

    task automatic scan_one(input logic [7:0] r, input logic [7:0] c, input logic [3:0] e);
        scan_req = 1'b1; scan_row = r; scan_col = c;
        exp_scan.push_back(e);
        smp(); adv();
        scan_req = 1'b0;
    endtask

    initial begin
        int busy, done, ack_t, done_t;
        rst_n = 1'b0; scan_req = 1'b0; scan_row = 8'h00; scan_col = 8'h00;
        pen_req = 1'b0; pen_row = 8'h00; pen_col = 8'h00; pen_data = 4'h0;
        clr_start = 1'b0; pl_en = 1'b0; pl_r = 3'd0; pl_c = 3'd0; pl_d = 4'h0;
        repeat (2) adv();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        smp(); adv();

        // Single scan read of a preloaded cell.
        pl_en = 1'b1; pl_r = 3'd2; pl_c = 3'd4; pl_d = 4'hA;
        smp(); adv();
        pl_en = 1'b0;
        scan_one(8'h04, 8'h10, 4'hA);
        smp();
        check("scan_ram_we", 32'(ram_we), 32'h0);
        check("scan_ram_row", 32'(ram_row), 32'h04);
        check("scan_ram_col", 32'(ram_col), 32'h10);
        adv();
        smp(); check("scan_valid_hi", 32'(scan_valid), 32'h1); adv();
        smp();
        check("idle_valid_lo", 32'(scan_valid), 32'h0);
        check("idle_row_hold", 32'(ram_row), 32'h04);
        adv();

        // Continuous scan starves the pen until the wait limit.
        scan_req = 1'b1; pen_req = 1'b1; pen_row = 8'h01; pen_col = 8'h01; pen_data = 4'h5;
        for (int k = 0; k < 8; k++) begin
            if (k == 5) pen_req = 1'b0;
            if (k == 6) scan_req = 1'b0;
            if (k < 6 && k != 4) exp_scan.push_back(4'hA);
            if (k == 4) push_wr(8'h01, 8'h01, 4'h5);
            smp();
            if (k <= 4) check("starve_pen_ack", 32'(pen_ack), 32'(k == 4));
            if (k == 4) check("starve_pen_err", 32'(pen_err), 32'h0);
            if (k == 5) check("starve_ram_we", 32'(ram_we), 32'h1);
            if (k == 6) check("starve_scan_gap", 32'(scan_valid), 32'h0);
            adv();
        end

        // Pen requests with non-one-hot addresses are rejected.
        pen_req = 1'b1; pen_row = 8'h03; pen_col = 8'h01; pen_data = 4'h7;
        smp(); check("bad_row_ack", 32'(pen_ack), 32'h1); check("bad_row_err", 32'(pen_err), 32'h1); adv();
        pen_req = 1'b0;
        smp(); check("bad_row_no_we", 32'(ram_we), 32'h0); adv();
        pen_req = 1'b1; pen_row = 8'h02; pen_col = 8'h00;
        smp(); check("zero_col_ack", 32'(pen_ack), 32'h1); check("zero_col_err", 32'(pen_err), 32'h1); adv();
        pen_req = 1'b0;
        smp(); check("zero_col_no_we", 32'(ram_we), 32'h0); adv();

        // Non-one-hot scan address is forwarded unchanged.
        scan_one(8'h03, 8'h01, 4'h0);
        smp(); check("bad_scan_row", 32'(ram_row), 32'h03); check("bad_scan_we", 32'(ram_we), 32'h0); adv();
        smp(); adv();

        // Full clear sweep; scans and a second clr_start during the sweep are ignored.
        push_clear(64);
        clr_start = 1'b1;
        smp(); check("clr_start_busy", 32'(clr_busy), 32'h0); adv();
        clr_start = 1'b0;
        busy = 0; done = 0;
        for (int t = 1; t <= 80; t++) begin
            scan_req = (t < 40); scan_row = 8'h01; scan_col = 8'h01;
            clr_start = (t == 30);
            smp();
            if (clr_busy) busy++;
            if (clr_done) begin
                done++;
                check("clr_done_busy_lo", 32'(clr_busy), 32'h0);
            end
            if (t >= 2 && t <= 41) check("clr_scan_blocked", 32'(scan_valid), 32'h0);
            adv();
        end
        scan_req = 1'b0; clr_start = 1'b0;
        check("clr_busy_cycles", 32'(busy), 32'd64);
        check("clr_done_pulses", 32'(done), 32'd1);
        check("clr_writes_left", 32'(exp_wr.size()), 32'd0);

        // Clear and pen in the same cycle: clear first, then the pen write.
        push_clear(64);
        push_wr(8'h02, 8'h08, 4'h9);
        clr_start = 1'b1; pen_req = 1'b1; pen_row = 8'h02; pen_col = 8'h08; pen_data = 4'h9;
        smp(); check("clr_pen_no_ack", 32'(pen_ack), 32'h0); adv();
        clr_start = 1'b0;
        ack_t = 0; done_t = 0;
        for (int t = 1; t <= 80; t++) begin
            smp();
            if (pen_ack && ack_t == 0) ack_t = t;
            if (clr_done) done_t = t;
            adv();
            if (ack_t != 0) pen_req = 1'b0;
        end
        pen_req = 1'b0;
        check("pen_ack_after_done", 32'(done_t != 0 && ack_t >= done_t), 32'h1);
        check("clr_pen_writes_left", 32'(exp_wr.size()), 32'd0);
        scan_one(8'h02, 8'h08, 4'h9);
        scan_one(8'h01, 8'h01, 4'h0);
        scan_one(8'h04, 8'h10, 4'h0);
        repeat (3) begin smp(); adv(); end

        // Reset at sweep index 20 aborts the clear.
        push_clear(19);
        clr_start = 1'b1;
        smp(); adv();
        clr_start = 1'b0;
        repeat (20) begin smp(); adv(); end
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midsweep");
        smp(); adv();
        rst_n = 1'b1;
        busy = 0; done = 0;
        for (int t = 0; t < 80; t++) begin
            smp();
            if (clr_busy) busy++;
            if (clr_done) done++;
            adv();
        end
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_done", 32'(done), 32'd0);
        check("post_rst_writes_left", 32'(exp_wr.size()), 32'd0);

        // Back in RUN: a pen write followed by a readback.
        push_wr(8'h80, 8'h80, 4'hC);
        pen_req = 1'b1; pen_row = 8'h80; pen_col = 8'h80; pen_data = 4'hC;
        smp(); check("post_rst_pen_ack", 32'(pen_ack), 32'h1); adv();
        pen_req = 1'b0;
        smp(); adv();
        scan_one(8'h80, 8'h80, 4'hC);
        repeat (3) begin smp(); adv(); end
        check("scan_queue_empty", 32'(exp_scan.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
